mnist_seq_ctrl: RTL
===================

Name: mnist_seq_ctrl

Overview:
- Top-level sequencer for the MNIST accelerator inside the NICE coprocessor.
- On a start command it runs these steps in order: weight DMA (ITCM to conv/FC weight buffers), conv engine, FC engines. It then returns the classification result.
- Loaded weights are tracked, so later inferences skip the DMA. An explicit reload re-arms the DMA through a dedicated DMA reset.
- A watchdog aborts any step that stalls.

Parameters:
AW, 16, weight-length width (matches DMA address width)
CLS_W, 4, class-index width
TO_W, 20, watchdog counter width; a step times out after 2^TO_W-1 cycles

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous active-low reset
i_start  in  1  start pulse from NICE decode; ignored unless in IDLE
i_reload  in  1  sampled with i_start; 1 forces a weight reload
i_conv_weight_length  in  AW  conv weight word count
i_fc_weight_length  in  AW  per-bank FC weight word count
o_conv_weight_length  out  AW  length latched at start, held stable to DMA
o_fc_weight_length  out  AW  length latched at start, held stable to DMA
o_dma_rst_n  out  1  synchronous active-low reset to DMA
o_dma_start  out  1  one-cycle DMA start pulse
i_dma_conv_load_finish  in  1  DMA level flag: conv weights written
i_dma_finish  in  1  DMA level flag: all FC banks written
o_conv_start  out  1  one-cycle conv engine start pulse
i_conv_done  in  1  conv engine done pulse
o_fc_start  out  1  one-cycle FC engine start pulse
i_fc_done  in  1  FC done pulse, qualifies i_fc_class
i_fc_class  in  CLS_W  argmax class
o_busy  out  1  high whenever state is not IDLE
o_done  out  1  one-cycle completion pulse
o_class  out  CLS_W  registered result, held until next done
o_error  out  1  sticky timeout flag; cleared by the next accepted i_start
o_weights_valid  out  1  weights resident in buffers

Behaviour:
- Reset values:
  - state IDLE; all pulse outputs 0; o_busy 0; o_class 0; o_error 0; o_weights_valid 0; both length outputs 0.
  - o_dma_rst_n is 0 during reset and for one cycle after reset releases, then 1.
- States: IDLE, DMA_RST, DMA_KICK, WAIT_CONVW, CONV_RUN, WAIT_FCW, FC_RUN, DONE.
- IDLE, on i_start:
  - Latch both lengths and clear o_error.
  - If i_reload=1 or o_weights_valid=0: clear o_weights_valid and go to DMA_RST.
  - Otherwise go directly to CONV_RUN and assert o_conv_start on the entry cycle.
- DMA_RST: drive o_dma_rst_n=0 for exactly one cycle. This clears the DMA's sticky flags. Go to DMA_KICK.
- DMA_KICK: o_dma_start=1 for one cycle. Go to WAIT_CONVW.
- WAIT_CONVW: wait for i_dma_conv_load_finish=1, then pulse o_conv_start and go to CONV_RUN. Conv compute overlaps the FC weight load.
- CONV_RUN, on i_conv_done:
  - If i_dma_finish=1 or weights are already valid, pulse o_fc_start and go to FC_RUN.
  - Otherwise go to WAIT_FCW.
- WAIT_FCW: on i_dma_finish, set o_weights_valid, pulse o_fc_start, go to FC_RUN.
  - o_weights_valid is also set in CONV_RUN if i_dma_finish is seen there.
- FC_RUN: on i_fc_done, register i_fc_class into o_class and go to DONE.
- DONE: o_done=1 for one cycle, then IDLE. o_busy falls on the IDLE cycle.
- Latency, weights resident: i_start at cycle N gives o_conv_start at N+1.
- Latency, reload: i_start at N gives o_dma_rst_n low at N+1 and o_dma_start at N+2.
- Watchdog:
  - Counter clears on every state change and counts in every non-IDLE state.
  - At all-ones: set o_error, drop o_weights_valid, go to IDLE with no o_done. The DMA is reset on the next start.
- Simultaneous events:
  - i_start while busy is ignored.
  - i_conv_done arriving together with i_dma_finish in CONV_RUN goes straight to FC_RUN.
  - Done pulses in non-waiting states are ignored.
- Reset mid-operation: immediate return to reset values. o_dma_rst_n is held low during reset, so the DMA is reset as well.
- Length outputs change only when i_start is accepted.

Decomposition:
- Package mnist_pkg holds the state enum encoding (3-bit), CLS_W, and TO_W defaults.
- One sub-module, seq_watchdog:
  - Inputs: clear, enable.
  - Output: expire.
  - Contains a TO_W counter.
- The FSM stays in the top module.

Test Plan:
- Cold start: i_start with i_reload=0, conv len 72, fc len 196, DMA model sets conv_load_finish at +80 and finish at +900, conv_done at +300, fc_done at +1000 with class 7.
  - Expect o_dma_rst_n low at +1 and o_dma_start at +2.
  - Expect o_conv_start the cycle after conv_load_finish.
  - Expect o_fc_start the cycle after dma_finish.
  - Expect o_class=7, then o_done, then o_weights_valid=1.
- Warm start: second i_start with i_reload=0.
  - Expect no DMA reset or start; o_conv_start at N+1.
  - After conv_done, o_fc_start the next cycle.
- Forced reload: i_start with i_reload=1 after a warm run.
  - Expect o_weights_valid to drop, a one-cycle DMA reset, then o_dma_start.
- Overlap: i_conv_done in the same cycle i_dma_finish first rises.
  - Expect o_fc_start the next cycle and WAIT_FCW skipped.
- Timeout: TO_W=6, DMA never finishes.
  - Expect o_error=1 and o_busy=0 64 cycles after the last state change, no o_done, o_weights_valid=0.
  - The next i_start clears o_error.
- Reset mid-run: assert i_rst_n=0 in CONV_RUN.
  - Expect all outputs at reset values and o_dma_rst_n=0.
  - i_start during busy has no effect.

Source files
------------

// File: rtl/mnist_seq_ctrl_pkg.sv
// Shared state encoding and default widths for the MNIST accelerator sequencer.
package mnist_pkg;

  localparam int AW_DEF    = 16;
  localparam int CLS_W_DEF = 4;
  localparam int TO_W_DEF  = 20;

  typedef logic [2:0] seq_state_t;

  localparam seq_state_t ST_IDLE       = 3'd0;
  localparam seq_state_t ST_DMA_RST    = 3'd1;
  localparam seq_state_t ST_DMA_KICK   = 3'd2;
  localparam seq_state_t ST_WAIT_CONVW = 3'd3;
  localparam seq_state_t ST_CONV_RUN   = 3'd4;
  localparam seq_state_t ST_WAIT_FCW   = 3'd5;
  localparam seq_state_t ST_FC_RUN     = 3'd6;
  localparam seq_state_t ST_DONE       = 3'd7;

  // States in which the FC weight load may still be completing in the background.
  function automatic logic fc_weights_pending(input seq_state_t s);
    return (s == ST_CONV_RUN) || (s == ST_WAIT_FCW);
  endfunction

endpackage

// File: rtl/mnist_seq_ctrl_if.sv
// Handshake bundle between the sequencer and the weight DMA, conv engine and FC engines.
interface mnist_seq_ctrl_if #(
  parameter int AW    = 16,
  parameter int CLS_W = 4
);

  logic [AW-1:0]    conv_weight_length;
  logic [AW-1:0]    fc_weight_length;
  logic             dma_rst_n;
  logic             dma_start;
  logic             dma_conv_load_finish;
  logic             dma_finish;
  logic             conv_start;
  logic             conv_done;
  logic             fc_start;
  logic             fc_done;
  logic [CLS_W-1:0] fc_class;

  modport master (
    output conv_weight_length,
    output fc_weight_length,
    output dma_rst_n,
    output dma_start,
    input  dma_conv_load_finish,
    input  dma_finish,
    output conv_start,
    input  conv_done,
    output fc_start,
    input  fc_done,
    input  fc_class
  );

  modport slave (
    input  conv_weight_length,
    input  fc_weight_length,
    input  dma_rst_n,
    input  dma_start,
    output dma_conv_load_finish,
    output dma_finish,
    input  conv_start,
    output conv_done,
    input  fc_start,
    output fc_done,
    output fc_class
  );

endinterface

// File: rtl/mnist_seq_ctrl_seq_watchdog.sv
// Step watchdog: counts cycles spent in one sequencer state and flags a stall at all-ones.
module seq_watchdog #(
  parameter int TO_W = 20
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [TO_W-1:0] count;

  assign expire = &count;

  // Saturates at all-ones so expire stays asserted until the owner clears it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mnist_seq_ctrl.sv
// Top-level sequencer for the MNIST accelerator: weight DMA, conv engine, FC engines, result.
module mnist_seq_ctrl
  import mnist_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int CLS_W = CLS_W_DEF,
  parameter int TO_W  = TO_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_reload,
  input  logic [AW-1:0]    i_conv_weight_length,
  input  logic [AW-1:0]    i_fc_weight_length,
  output logic             o_busy,
  output logic             o_done,
  output logic [CLS_W-1:0] o_class,
  output logic             o_error,
  output logic             o_weights_valid,
  mnist_seq_ctrl_if.master eng
);

  seq_state_t    state;
  seq_state_t    state_nxt;
  logic          accept;
  logic          need_dma;
  logic          timeout;
  logic          wd_expire;
  logic          conv_start_q;
  logic          fc_start_q;
  logic          rst_seen_q;
  logic          dma_rst_n_q;
  logic [AW-1:0] conv_len_q;
  logic [AW-1:0] fc_len_q;

  seq_watchdog #(
    .TO_W (TO_W)
  ) u_watchdog (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .clear   (state_nxt != state),
    .enable  (state != ST_IDLE),
    .expire  (wd_expire)
  );

  // Next-state logic; a watchdog expiry overrides whatever the current step was waiting on.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    need_dma  = i_reload || !o_weights_valid;
    timeout   = wd_expire && (state != ST_IDLE);
    if (timeout) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            accept    = 1'b1;
            state_nxt = need_dma ? ST_DMA_RST : ST_CONV_RUN;
          end
        end
        ST_DMA_RST:  state_nxt = ST_DMA_KICK;
        ST_DMA_KICK: state_nxt = ST_WAIT_CONVW;
        ST_WAIT_CONVW: begin
          if (eng.dma_conv_load_finish) state_nxt = ST_CONV_RUN;
        end
        ST_CONV_RUN: begin
          if (eng.conv_done) begin
            state_nxt = (eng.dma_finish || o_weights_valid) ? ST_FC_RUN : ST_WAIT_FCW;
          end
        end
        ST_WAIT_FCW: begin
          if (eng.dma_finish) state_nxt = ST_FC_RUN;
        end
        ST_FC_RUN: begin
          if (eng.fc_done) state_nxt = ST_DONE;
        end
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // The DMA reset is held one extra cycle past our own reset so the DMA sees a clean release.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state           <= ST_IDLE;
      conv_start_q    <= 1'b0;
      fc_start_q      <= 1'b0;
      rst_seen_q      <= 1'b0;
      dma_rst_n_q     <= 1'b0;
      conv_len_q      <= '0;
      fc_len_q        <= '0;
      o_class         <= '0;
      o_error         <= 1'b0;
      o_weights_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      conv_start_q <= (state_nxt == ST_CONV_RUN) && (state != ST_CONV_RUN);
      fc_start_q   <= (state_nxt == ST_FC_RUN) && (state != ST_FC_RUN);
      rst_seen_q   <= 1'b1;
      dma_rst_n_q  <= rst_seen_q && (state_nxt != ST_DMA_RST);

      if (accept) begin
        conv_len_q <= i_conv_weight_length;
        fc_len_q   <= i_fc_weight_length;
      end

      if (timeout) begin
        o_error <= 1'b1;
      end else if (accept) begin
        o_error <= 1'b0;
      end

      if (timeout || (accept && need_dma)) begin
        o_weights_valid <= 1'b0;
      end else if (fc_weights_pending(state) && eng.dma_finish) begin
        o_weights_valid <= 1'b1;
      end

      if (!timeout && (state == ST_FC_RUN) && eng.fc_done) begin
        o_class <= eng.fc_class;
      end
    end
  end

  assign o_busy                 = (state != ST_IDLE);
  assign o_done                 = (state == ST_DONE);
  assign eng.dma_start          = (state == ST_DMA_KICK);
  assign eng.dma_rst_n          = dma_rst_n_q;
  assign eng.conv_start         = conv_start_q;
  assign eng.fc_start           = fc_start_q;
  assign eng.conv_weight_length = conv_len_q;
  assign eng.fc_weight_length   = fc_len_q;

endmodule
